// File: rtl/sram_pkg.sv
// Shared types and default parameters for the 16-bit asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned DefBaseAddr   = 1024;
  localparam int unsigned DefWaitCycles = 2;
  localparam int unsigned DefSramAw     = 18;
  localparam int unsigned DefSramDw     = 16;

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase wait counter: load starts a phase, last flags its final clock.
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WAIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntInit;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data port responder: each 32-bit access runs as two half-word
// phases (low then high) on an off-chip 16-bit asynchronous SRAM.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DefBaseAddr,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles,
  parameter int unsigned SRAM_AW     = DefSramAw,
  parameter int unsigned SRAM_DW     = DefSramDw
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_W_EN,
  input  logic                   MEM_R_EN,
  input  logic [31:0]            address,
  input  logic [2*SRAM_DW-1:0]   write_data,
  output logic [2*SRAM_DW-1:0]   read_data,
  output logic                   ready,
  output logic [SRAM_AW-1:0]     SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0]     SRAM_DQ,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N
);

  localparam int unsigned WordW = SRAM_AW - 1;

  state_e               state_q, state_d;
  logic                 is_write_q, is_write_d;
  logic [WordW-1:0]     word_q, word_d;
  logic [2*SRAM_DW-1:0] wdata_q, wdata_d;
  logic [SRAM_DW-1:0]   rd_lo_q, rd_lo_d;
  logic [2*SRAM_DW-1:0] read_data_q, read_data_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;

  logic             req;
  logic             timer_load, timer_en, timer_last;
  logic [31:0]      offset;
  logic [WordW-1:0] word_in;
  logic             unused_offset_bits;

  assign req     = MEM_W_EN | MEM_R_EN;
  // Addresses below BASE_ADDR wrap around the SRAM word space.
  assign offset  = address - 32'(BASE_ADDR);
  assign word_in = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .last (timer_last)
  );

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rd_lo_d     = rd_lo_q;
    read_data_d = read_data_q;
    timer_load  = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d    = StLow;
          // A simultaneous read+write request is served as a write.
          is_write_d = MEM_W_EN;
          word_d     = word_in;
          wdata_d    = write_data;
          timer_load = 1'b1;
        end
      end
      StLow: begin
        timer_en = 1'b1;
        if (timer_last) begin
          state_d    = StHigh;
          timer_load = 1'b1;
          if (!is_write_q) rd_lo_d = SRAM_DQ;
        end
      end
      StHigh: begin
        timer_en = 1'b1;
        if (timer_last) begin
          state_d = StDone;
          if (!is_write_q) read_data_d = {SRAM_DQ, rd_lo_q};
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pin outputs are registered from the next state so they switch on phase entry.
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    if (state_d == StLow || state_d == StHigh) begin
      addr_d   = {word_d, (state_d == StHigh)};
      dq_out_d = (state_d == StHigh) ? wdata_d[2*SRAM_DW-1:SRAM_DW] : wdata_d[SRAM_DW-1:0];
      we_n_d   = !is_write_d;
      oe_n_d   = is_write_d;
      dq_oe_d  = is_write_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      read_data_q <= '0;
      addr_q      <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rd_lo_q     <= rd_lo_d;
      read_data_q <= read_data_d;
      addr_q      <= addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign ready     = ((state_q == StIdle) && !req) || (state_q == StDone);
  assign read_data = read_data_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};

endmodule
